inst_fetcher: RTL

- Upstream neighbour of the decode/issue stage. Owns the architectural fetch PC and requests one instruction at a time from the instruction cache.
- Presents the fetched word and its address to the decoder as a registered valid/inst/inst_addr triple. Holds the word until the decoder's issue_signal consumes it.
- Redirects to the decoder-supplied next_pc on issue, or to correct_pc on a ROB misprediction flush. Safely discards an in-flight cache response that a flush has made stale.

---
 rtl/inst_fetcher_if.sv | 48 ++++
 rtl/inst_fetcher.sv | 132 +++++++++++++
 2 files changed

// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: the instruction-cache request/response pair, the decoder
// presentation triple with its issue/redirect inputs, and the ROB flush redirect.
//   master : inst_fetcher side (drives cache request and decoder outputs)
//   slave  : environment side (cache, decoder, ROB)
interface inst_fetcher_if;
    // Instruction cache
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_inst;
    // Decoder
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;
    logic        issue_signal;
    logic [31:0] next_pc;
    // ROB
    logic        wrong_predicted;
    logic [31:0] correct_pc;

    modport master (
        output icache_req,
        output icache_addr,
        input  icache_valid,
        input  icache_inst,
        output inst_valid,
        output inst_out,
        output inst_addr_out,
        input  issue_signal,
        input  next_pc,
        input  wrong_predicted,
        input  correct_pc
    );

    modport slave (
        input  icache_req,
        input  icache_addr,
        output icache_valid,
        output icache_inst,
        input  inst_valid,
        input  inst_out,
        input  inst_addr_out,
        output issue_signal,
        output next_pc,
        output wrong_predicted,
        output correct_pc
    );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher: owns the fetch PC, issues one icache request at a time and
// presents the returned word to the decoder until it is issued. Redirects on issue
// (next_pc) or ROB flush (correct_pc); a response outstanding across a flush is
// drained and dropped before the redirected request is issued.
// Ports:
//   clk_in  - clock
//   rst_in  - synchronous active-high reset
//   rdy_in  - global ready; low freezes every register
//   bus     - inst_fetcher_if.master (icache, decoder and ROB signals)
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk_in,
    input logic            rst_in,
    input logic            rdy_in,
    inst_fetcher_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;

    // Redirect targets are always word aligned.
    logic [31:0] correct_pc_al;
    logic [31:0] next_pc_al;
    assign correct_pc_al = {bus.correct_pc[31:2], 2'b00};
    assign next_pc_al    = {bus.next_pc[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;

        if (rdy_in) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.wrong_predicted) begin
                        pc_d = correct_pc_al;
                    end
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                    state_d = StFetch;
                end
                StFetch: begin
                    if (bus.wrong_predicted && bus.icache_valid) begin
                        // Response belongs to the flushed path; re-request immediately.
                        pc_d   = correct_pc_al;
                        addr_d = correct_pc_al;
                        req_d  = 1'b1;
                    end else if (bus.wrong_predicted) begin
                        // Request still in flight: keep its address stable and drain it.
                        pc_d    = correct_pc_al;
                        state_d = StDiscard;
                    end else if (bus.icache_valid) begin
                        inst_d      = bus.icache_inst;
                        inst_addr_d = pc_q;
                        valid_d     = 1'b1;
                        req_d       = 1'b0;
                        state_d     = StHold;
                    end
                end
                StHold: begin
                    if (bus.wrong_predicted) begin
                        valid_d = 1'b0;
                        pc_d    = correct_pc_al;
                        addr_d  = correct_pc_al;
                        req_d   = 1'b1;
                        state_d = StFetch;
                    end else if (bus.issue_signal) begin
                        valid_d = 1'b0;
                        pc_d    = next_pc_al;
                        addr_d  = next_pc_al;
                        req_d   = 1'b1;
                        state_d = StFetch;
                    end
                end
                StDiscard: begin
                    if (bus.wrong_predicted) begin
                        pc_d = correct_pc_al;
                    end
                    if (bus.icache_valid) begin
                        addr_d  = pc_d;
                        state_d = StFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            valid_q     <= 1'b0;
            inst_q      <= 32'h0;
            inst_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    assign bus.icache_req    = req_q;
    assign bus.icache_addr   = addr_q;
    assign bus.inst_valid    = valid_q;
    assign bus.inst_out      = inst_q;
    assign bus.inst_addr_out = inst_addr_q;

endmodule
